// File: rtl/regfile_initiator.sv
// Command-driven master for a 64x16 register file: READ/WRITE/COPY/ADD over valid/ready.
// Define REGFILE_REG0_PROTECT_EN to make register 0 read-only (writes report RespError).
module regfile_initiator #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [1:0]        CmdOp,
    input  logic [ADDR_W-1:0] CmdAddrA,
    input  logic [ADDR_W-1:0] CmdAddrB,
    input  logic [DATA_W-1:0] CmdData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespDataA,
    output logic [DATA_W-1:0] RespDataB,
    output logic              RespCarry,
    output logic              RespError,
    output logic [ADDR_W-1:0] AddressA,
    output logic [ADDR_W-1:0] AddressB,
    output logic [DATA_W-1:0] WriteData,
    output logic              WriteEnable,
    input  logic [DATA_W-1:0] ReadDataA,
    input  logic [DATA_W-1:0] ReadDataB
);

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RESP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

`ifdef REGFILE_REG0_PROTECT_EN
    localparam bit PROTECT_REG0 = 1'b1;
`else
    localparam bit PROTECT_REG0 = 1'b0;
`endif

    state_t              state_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   cmd_data_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [DATA_W-1:0]   resp_a_q;
    logic [DATA_W-1:0]   resp_b_q;
    logic                carry_q;
    logic                err_q;
    logic                cmd_ready_q;
    logic                resp_valid_q;

    logic [DATA_W:0]     sum;
    logic                reg0_blocked;

    assign sum          = {1'b0, ReadDataA} + {1'b0, ReadDataB};
    assign reg0_blocked = PROTECT_REG0 && (op_q != OP_READ) && (addr_a_q == '0);

    // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            cmd_data_q   <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            resp_a_q     <= '0;
            resp_b_q     <= '0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (CmdValid && cmd_ready_q) begin
                        op_q        <= CmdOp;
                        addr_a_q    <= CmdAddrA;
                        addr_b_q    <= CmdAddrB;
                        cmd_data_q  <= CmdData;
                        err_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_READ) begin
                        resp_a_q     <= ReadDataA;
                        resp_b_q     <= ReadDataB;
                        carry_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (reg0_blocked) begin
                        // Protected write: skip COMMIT so WriteEnable never pulses.
                        resp_a_q     <= '0;
                        resp_b_q     <= '0;
                        carry_q      <= 1'b0;
                        err_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        case (op_q)
                            OP_WRITE: begin
                                wdata_q <= cmd_data_q;
                                carry_q <= 1'b0;
                            end
                            OP_COPY: begin
                                wdata_q <= ReadDataB;
                                carry_q <= 1'b0;
                            end
                            default: {carry_q, wdata_q} <= sum;
                        endcase
                        we_q    <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    we_q         <= 1'b0;
                    resp_a_q     <= wdata_q;
                    resp_b_q     <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (RespReady) begin
                        resp_valid_q <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CmdReady    = cmd_ready_q;
    assign RespValid   = resp_valid_q;
    assign RespDataA   = resp_a_q;
    assign RespDataB   = resp_b_q;
    assign RespCarry   = carry_q;
    assign RespError   = err_q;
    assign AddressA    = addr_a_q;
    assign AddressB    = addr_b_q;
    assign WriteData   = wdata_q;
    assign WriteEnable = we_q;

endmodule
